// File: rtl/mda_pkg.sv
// Shared types and constants for the MDA CPU-side video memory port.
package mda_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SLOT = 2'd1,
      ACCESS    = 2'd2,
      HOLD      = 2'd3
   } vram_state_t;

   localparam logic [4:0] MDA_MEM_BASE      = 5'b10110;
   localparam logic [7:0] VRAM_TIMEOUT_DATA = 8'hFF;

   // True when the upper ISA address bits select the B0000-B7FFF window and no DMA owns the bus.
   function automatic logic in_window(input logic [4:0] a_hi, input logic aen);
      return (a_hi == MDA_MEM_BASE) && !aen;
   endfunction

endpackage

// File: rtl/mda_strobe_sync.sv
// Two-flop synchroniser for an active-low ISA strobe, plus a one-cycle pulse on its
// synchronised falling edge.
module mda_strobe_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_l,
   output logic sync_l,
   output logic fall
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= strobe_l;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign sync_l = sync_r;
   assign fall   = prev_r & ~sync_r;

endmodule

// File: rtl/mda_isa_vram.sv
// MDA CPU-side VRAM port: ISA decode, slot-aligned access, wait-state generation.
// Optional macro MDA_VRAM_READBACK_EN enables CPU reads; without it VRAM is write-only.
module mda_isa_vram
   import mda_pkg::*;
#(
   parameter int VRAM_AWIDTH = 12,
   parameter int MAX_WAIT    = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [19:0] bus_a,
   input  logic [7:0]  bus_d,
   input  logic        bus_memr_l,
   input  logic        bus_memw_l,
   input  logic        bus_aen,
   output logic [7:0]  bus_out,
   output logic        bus_dir,
   output logic        bus_rdy,
   input  logic        isa_op_enable,
   input  logic [18:0] pixel_addr,
   output logic [18:0] ram_a,
   input  logic [7:0]  ram_d,
   output logic [7:0]  ram_dout,
   output logic        ram_we_l
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   vram_state_t state_r, state_nxt;
   logic [18:0]    addr_r;
   logic [7:0]     data_r;
   logic           op_write_r;
   logic [WCW-1:0] wait_cnt_r;
   logic           bus_rdy_r, bus_rdy_nxt;
   logic           ram_we_l_r, ram_we_l_nxt;
   logic [7:0]     ram_dout_r, ram_dout_nxt;

   logic w_sync_s, w_fall_s, r_sync_s, r_fall_s;
   logic cs_s, wr_req_s, rd_req_s, timeout_s, op_sync_s;
   logic unused_bits;

   mda_strobe_sync u_sync_w (.clk(clk), .rst_n(rst_n), .strobe_l(bus_memw_l), .sync_l(w_sync_s), .fall(w_fall_s));
   mda_strobe_sync u_sync_r (.clk(clk), .rst_n(rst_n), .strobe_l(bus_memr_l), .sync_l(r_sync_s), .fall(r_fall_s));

   assign cs_s      = in_window(bus_a[19:15], bus_aen);
   assign wr_req_s  = cs_s & w_fall_s;
   assign timeout_s = (wait_cnt_r == WCW'(MAX_WAIT - 1));

`ifdef MDA_VRAM_READBACK_EN
   // A write falling in the same cycle wins over the read
   assign rd_req_s    = cs_s & r_fall_s & ~wr_req_s;
   assign op_sync_s   = op_write_r ? w_sync_s : r_sync_s;
   assign unused_bits = ^bus_a;
`else
   assign rd_req_s    = 1'b0;
   assign op_sync_s   = w_sync_s;
   assign unused_bits = ^{bus_a, ram_d, r_fall_s, r_sync_s};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         IDLE: begin
            if (wr_req_s || rd_req_s) state_nxt = WAIT_SLOT;
            else                      state_nxt = IDLE;
         end
         WAIT_SLOT: begin
            if (isa_op_enable)  state_nxt = ACCESS;
            else if (timeout_s) state_nxt = HOLD;
            else                state_nxt = WAIT_SLOT;
         end
         ACCESS: state_nxt = HOLD;
         HOLD: begin
            if (op_sync_s) state_nxt = IDLE;
            else           state_nxt = HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: VRAM address mux and next values of the registered outputs
   always_comb begin
      ram_a        = pixel_addr;
      bus_rdy_nxt  = !((state_nxt == WAIT_SLOT) || (state_nxt == ACCESS));
      ram_we_l_nxt = 1'b1;
      ram_dout_nxt = 8'h00;
      if (state_r == ACCESS) ram_a = addr_r;
      else                   ram_a = pixel_addr;
      if ((state_r == WAIT_SLOT) && (state_nxt == ACCESS) && op_write_r) begin
         ram_we_l_nxt = 1'b0;
         ram_dout_nxt = data_r;
      end else begin
         ram_we_l_nxt = 1'b1;
         ram_dout_nxt = 8'h00;
      end
   end

   // Request capture: address, data and direction latched on the accepted strobe edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r     <= 19'h00000;
         data_r     <= 8'h00;
         op_write_r <= 1'b0;
      end else if ((state_r == IDLE) && (wr_req_s || rd_req_s)) begin
         addr_r     <= 19'(bus_a[VRAM_AWIDTH-1:0]);
         data_r     <= bus_d;
         op_write_r <= wr_req_s;
      end
   end

   // Wait-state counter, saturating, cleared whenever the bus is ready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_r <= '0;
      end else if (bus_rdy_r) begin
         wait_cnt_r <= '0;
      end else if (wait_cnt_r != WCW'(MAX_WAIT)) begin
         wait_cnt_r <= wait_cnt_r + WCW'(1);
      end
   end

   // Registered bus/RAM control outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_rdy_r  <= 1'b1;
         ram_we_l_r <= 1'b1;
         ram_dout_r <= 8'h00;
      end else begin
         bus_rdy_r  <= bus_rdy_nxt;
         ram_we_l_r <= ram_we_l_nxt;
         ram_dout_r <= ram_dout_nxt;
      end
   end

   assign bus_rdy  = bus_rdy_r;
   assign ram_we_l = ram_we_l_r;
   assign ram_dout = ram_dout_r;

`ifdef MDA_VRAM_READBACK_EN
   logic [7:0] bus_out_r, bus_out_nxt;
   logic       bus_dir_r, bus_dir_nxt;

   // Read capture: VRAM data after the slot, or the timeout pattern when the slot never came
   always_comb begin
      bus_out_nxt = bus_out_r;
      bus_dir_nxt = bus_dir_r;
      if ((state_r == ACCESS) && !op_write_r) begin
         bus_out_nxt = ram_d;
         bus_dir_nxt = 1'b1;
      end else if ((state_r == WAIT_SLOT) && (state_nxt == HOLD) && !op_write_r) begin
         bus_out_nxt = VRAM_TIMEOUT_DATA;
         bus_dir_nxt = 1'b1;
      end else if ((state_r == HOLD) && (state_nxt == IDLE)) begin
         bus_dir_nxt = 1'b0;
      end else begin
         bus_dir_nxt = bus_dir_r;
      end
   end

   // Read data and direction registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_out_r <= 8'h00;
         bus_dir_r <= 1'b0;
      end else begin
         bus_out_r <= bus_out_nxt;
         bus_dir_r <= bus_dir_nxt;
      end
   end

   assign bus_out = bus_out_r;
   assign bus_dir = bus_dir_r;
`else
   assign bus_out = 8'h00;
   assign bus_dir = 1'b0;
`endif

endmodule

// File: tb/tb_mda_isa_vram.sv
// Directed, table-driven bench for mda_isa_vram (default and MDA_VRAM_READBACK_EN builds).
module tb_mda_isa_vram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_memr_l, bus_memw_l, bus_aen;
   logic [7:0]  bus_out;
   logic        bus_dir, bus_rdy;
   logic        isa_op_enable;
   logic [18:0] pixel_addr;
   logic [18:0] ram_a;
   logic [7:0]  ram_d;
   logic [7:0]  ram_dout;
   logic        ram_we_l;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mda_isa_vram dut (
      .clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_d(bus_d),
      .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
      .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
      .isa_op_enable(isa_op_enable), .pixel_addr(pixel_addr),
      .ram_a(ram_a), .ram_d(ram_d), .ram_dout(ram_dout), .ram_we_l(ram_we_l)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [19:0] addr;
      logic [7:0]  data;
      logic        aen;
      int          slot;      // iteration carrying isa_op_enable, 0 = never
      int          rel;       // iteration releasing the strobe(s)
      int          len;
      logic [7:0]  rd_data;   // ram_d driven during the ACCESS cycle
      int          exp_we;
      logic [18:0] exp_a;
      logic [7:0]  exp_dout;
      int          exp_rdy_low;
      int          exp_dir;
      logic        chk_out;
      logic [7:0]  exp_out;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic wr, input logic rd, input logic [19:0] addr,
                               input logic [7:0] data, input logic aen, input int slot,
                               input int rel, input int len, input logic [7:0] rd_data,
                               input int exp_we, input logic [18:0] exp_a,
                               input logic [7:0] exp_dout, input int exp_rdy_low,
                               input int exp_dir, input logic chk_out,
                               input logic [7:0] exp_out);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.aen = aen;
      v.slot = slot; v.rel = rel; v.len = len; v.rd_data = rd_data;
      v.exp_we = exp_we; v.exp_a = exp_a; v.exp_dout = exp_dout;
      v.exp_rdy_low = exp_rdy_low; v.exp_dir = exp_dir;
      v.chk_out = chk_out; v.exp_out = exp_out;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          we_cnt  = 0;
      int          we_iter = -1;
      int          rdy_low = 0;
      int          dir_cnt = 0;
      int          pix_bad = 0;
      int          acc_iter;
      logic [18:0] got_a   = 19'h0;
      logic [7:0]  got_d   = 8'h0;
      logic [18:0] acc_a   = 19'h0;
      logic        last_rdy = 1'b0;
      acc_iter = (v.exp_rdy_low > 0 && v.slot != 0) ? v.slot + 1 : -1;
      for (int c = 0; c < v.len; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            bus_a = v.addr; bus_d = v.data; bus_aen = v.aen;
            if (v.wr) bus_memw_l = 1'b0;
            if (v.rd) bus_memr_l = 1'b0;
         end
         if (c == 4) begin
            bus_a = 20'h00000; bus_d = 8'h00; bus_aen = 1'b0;
         end
         if (c == v.rel) begin
            bus_memw_l = 1'b1; bus_memr_l = 1'b1;
         end
         isa_op_enable = (v.slot != 0 && c == v.slot);
         ram_d         = (v.slot != 0 && c == v.slot + 1) ? v.rd_data : 8'hEE;
         pixel_addr    = 19'h50000 + 19'(c);
         @(negedge clk);
         if (!ram_we_l) begin
            we_cnt++; we_iter = c; got_a = ram_a; got_d = ram_dout;
         end
         if (!bus_rdy) rdy_low++;
         if (bus_dir)  dir_cnt++;
         if (c == acc_iter) acc_a = ram_a;
         else if (ram_a !== pixel_addr) pix_bad++;
         last_rdy = bus_rdy;
      end
      isa_op_enable = 1'b0;
      check($sformatf("v%0d we_pulses", idx), 32'(we_cnt), 32'(v.exp_we));
      if (v.exp_we > 0) begin
         check($sformatf("v%0d we_addr", idx), 32'(got_a), 32'(v.exp_a));
         check($sformatf("v%0d we_data", idx), 32'(got_d), 32'(v.exp_dout));
         check($sformatf("v%0d we_cycle", idx), 32'(we_iter), 32'(v.slot + 1));
      end
      if (acc_iter >= 0) check($sformatf("v%0d access_addr", idx), 32'(acc_a), 32'(v.exp_a));
      check($sformatf("v%0d rdy_low_cycles", idx), 32'(rdy_low), 32'(v.exp_rdy_low));
      check($sformatf("v%0d dir_cycles", idx), 32'(dir_cnt), 32'(v.exp_dir));
      if (v.chk_out) check($sformatf("v%0d bus_out", idx), 32'(bus_out), 32'(v.exp_out));
      check($sformatf("v%0d pixel_passthru_errs", idx), 32'(pix_bad), 32'd0);
      check($sformatf("v%0d final_rdy", idx), 32'(last_rdy), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int we_cnt;
      int rdy_low_after;
      logic rdy_before;

      rst_n = 1'b0; bus_a = 20'h0; bus_d = 8'h0; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
      bus_aen = 1'b0; isa_op_enable = 1'b0; pixel_addr = 19'h1234A; ram_d = 8'hEE;

      //              wr    rd    addr       data   aen  slot rel len rd_d   we a         dout   rdy dir chk out
      vecs[0] = mk(1'b1, 1'b0, 20'hB0123, 8'h5A, 1'b0, 10, 13, 18, 8'hEE, 1, 19'h00123, 8'h5A,  9, 0, 1'b0, 8'h00);
      vecs[1] = mk(1'b1, 1'b0, 20'hB1123, 8'hA5, 1'b0,  5,  8, 14, 8'hEE, 1, 19'h00123, 8'hA5,  4, 0, 1'b0, 8'h00);
      vecs[2] = mk(1'b1, 1'b0, 20'hB8000, 8'h11, 1'b0,  5,  8, 14, 8'hEE, 0, 19'h00000, 8'h00,  0, 0, 1'b0, 8'h00);
      vecs[3] = mk(1'b1, 1'b0, 20'hB0456, 8'h22, 1'b1,  5,  8, 14, 8'hEE, 0, 19'h00000, 8'h00,  0, 0, 1'b0, 8'h00);
      vecs[4] = mk(1'b1, 1'b0, 20'hB7FFF, 8'h3C, 1'b0,  3,  6, 11, 8'hEE, 1, 19'h00FFF, 8'h3C,  2, 0, 1'b0, 8'h00);
      vecs[5] = mk(1'b1, 1'b0, 20'hB0ABC, 8'h77, 1'b0, 12,  2, 18, 8'hEE, 1, 19'h00ABC, 8'h77, 11, 0, 1'b0, 8'h00);
      vecs[6] = mk(1'b1, 1'b0, 20'hB0321, 8'h44, 1'b0,  0, 70, 76, 8'hEE, 0, 19'h00000, 8'h00, 63, 0, 1'b0, 8'h00);
`ifdef MDA_VRAM_READBACK_EN
      vecs[7] = mk(1'b0, 1'b1, 20'hB0000, 8'h00, 1'b0,  6, 10, 16, 8'hC3, 0, 19'h00000, 8'h00,  5, 5, 1'b1, 8'hC3);
      vecs[8] = mk(1'b0, 1'b1, 20'hB0010, 8'h00, 1'b0,  0, 70, 76, 8'hEE, 0, 19'h00010, 8'h00, 63, 7, 1'b1, 8'hFF);
      vecs[9] = mk(1'b1, 1'b1, 20'hB0200, 8'h99, 1'b0,  5,  8, 14, 8'hEE, 1, 19'h00200, 8'h99,  4, 0, 1'b1, 8'hFF);
`else
      vecs[7] = mk(1'b0, 1'b1, 20'hB0000, 8'h00, 1'b0,  6, 10, 16, 8'hC3, 0, 19'h00000, 8'h00,  0, 0, 1'b1, 8'h00);
      vecs[8] = mk(1'b0, 1'b1, 20'hB0010, 8'h00, 1'b0,  0, 70, 76, 8'hEE, 0, 19'h00010, 8'h00,  0, 0, 1'b1, 8'h00);
      vecs[9] = mk(1'b1, 1'b1, 20'hB0200, 8'h99, 1'b0,  5,  8, 14, 8'hEE, 1, 19'h00200, 8'h99,  4, 0, 1'b1, 8'h00);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset bus_rdy", 32'(bus_rdy), 32'd1);
      check("reset bus_dir", 32'(bus_dir), 32'd0);
      check("reset bus_out", 32'(bus_out), 32'h00);
      check("reset ram_we_l", 32'(ram_we_l), 32'd1);
      check("reset ram_dout", 32'(ram_dout), 32'h00);
      check("reset ram_a", 32'(ram_a), 32'h1234A);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset while waiting for the slot: the pending write must be abandoned
      we_cnt = 0; rdy_low_after = 0; rdy_before = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin bus_a = 20'hB0050; bus_d = 8'h66; bus_memw_l = 1'b0; end
         if (c == 5) begin rst_n = 1'b0; bus_memw_l = 1'b1; end
         if (c == 6) rst_n = 1'b1;
         isa_op_enable = (c == 9);
         pixel_addr = 19'h60000 + 19'(c);
         @(negedge clk);
         if (!ram_we_l) we_cnt++;
         if (c == 4) rdy_before = bus_rdy;
         if (c >= 6 && !bus_rdy) rdy_low_after++;
      end
      isa_op_enable = 1'b0;
      check("midreset rdy_low_before", 32'(rdy_before), 32'd0);
      check("midreset we_pulses", 32'(we_cnt), 32'd0);
      check("midreset rdy_low_after", 32'(rdy_low_after), 32'd0);
      repeat (2) @(posedge clk);

      // Normal write after the mid-operation reset
      run_vec(vecs[1], 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
